// File: rtl/bias_a_exerciser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bias_a_exerciser : clocked stimulus/checker for the Y = A | (B & C) gate
// Revision 1.0
// ----------------------------------------------------------------------------
module bias_a_exerciser #(
   parameter int SETTLE_CYCLES = 2,
   parameter int NUM_PASSES    = 1,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             y_i,
   output logic             a_o,
   output logic             b_o,
   output logic             c_o,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic             first_fail_valid,
   output logic [2:0]       first_fail_vec
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_CHECK  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [7:0] c_PASS_LAST   = 8'(NUM_PASSES - 1);

   state_t           r_state;
   logic [2:0]       r_vec;
   logic [7:0]       r_pass_idx;
   logic [3:0]       r_settle;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [CNT_W-1:0] r_err;
   logic             r_ff_valid;
   logic [2:0]       r_ff_vec;

   logic             w_exp;
   logic             w_mismatch;
   logic             w_last;
   logic [CNT_W-1:0] w_err_next;

   // The drive register doubles as the vector index: {a,b,c} == vec.
   assign w_exp      = r_vec[2] | (r_vec[1] & r_vec[0]);
   assign w_mismatch = (y_i != w_exp);
   assign w_last     = (r_vec == 3'd7) && (r_pass_idx == c_PASS_LAST);
   assign w_err_next = (w_mismatch && !(&r_err)) ? r_err + CNT_W'(1) : r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_vec      <= 3'd0;
         r_pass_idx <= 8'd0;
         r_settle   <= 4'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_err      <= '0;
         r_ff_valid <= 1'b0;
         r_ff_vec   <= 3'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_err      <= '0;
                  r_ff_valid <= 1'b0;
                  r_ff_vec   <= 3'd0;
                  r_pass     <= 1'b0;
                  r_vec      <= 3'd0;
                  r_pass_idx <= 8'd0;
                  r_settle   <= 4'd0;
                  r_busy     <= 1'b1;
                  r_state    <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (r_settle == c_SETTLE_LAST) begin
                  r_state <= S_CHECK;
               end else begin
                  r_settle <= r_settle + 4'd1;
               end
            end
            S_CHECK: begin
               r_err <= w_err_next;
               if (w_mismatch && !r_ff_valid) begin
                  r_ff_valid <= 1'b1;
                  r_ff_vec   <= r_vec;
               end
               if (w_last) begin
                  // Pass uses the post-update count so it is valid alongside done.
                  r_pass  <= (w_err_next == '0);
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_vec   <= 3'd0;
                  r_state <= S_DONE;
               end else begin
                  if (r_vec == 3'd7) begin
                     r_pass_idx <= r_pass_idx + 8'd1;
                  end
                  r_vec    <= r_vec + 3'd1;
                  r_settle <= 4'd0;
                  r_state  <= S_SETTLE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign a_o              = r_vec[2];
   assign b_o              = r_vec[1];
   assign c_o              = r_vec[0];
   assign busy             = r_busy;
   assign done             = r_done;
   assign pass             = r_pass;
   assign err_count        = r_err;
   assign first_fail_valid = r_ff_valid;
   assign first_fail_vec   = r_ff_vec;

endmodule
`default_nettype wire
